stage2: RTL

- Decode / register-read stage with ID/EX pipeline register, directly upstream of stage3.
- Inputs: fetched instruction and PC from the IF/ID buffer, plus the writeback bundle returned from stage3 (out_regWrite, out_rd, muxOut).
- Holds the 64x32 register file, decodes control, sign-extends the immediate.
- Registers all results into the exact signal set stage3 consumes.

---
 rtl/stage2_pkg.sv | 52 +++++
 rtl/stage2_regfile64.sv | 41 ++++
 rtl/stage2.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/stage2_pkg.sv
// Shared decode constants for the decode/register-read stage: widths,
// opcode values, ALU operation codes and instruction field positions.
package stage2_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 6;
   localparam int IMM_W  = 16;

   // Opcodes live in the top nibble of the instruction
   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_NEG  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_BRZ  = 4'b1001;
   localparam logic [3:0] OP_JM   = 4'b1010;
   localparam logic [3:0] OP_BRN  = 4'b1011;
   localparam logic [3:0] OP_LD   = 4'b1110;
   localparam logic [3:0] OP_SVPC = 4'b1111;

   // ALU operation codes, shared with the execute stage
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_NEG   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;
   localparam logic [2:0] ALU_PASSA = 3'b100;

   // Instruction field bit positions
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 28;
   localparam int RD_HI  = 27;
   localparam int RD_LO  = 22;
   localparam int RS_HI  = 21;
   localparam int RS_LO  = 16;
   localparam int RT_HI  = 15;
   localparam int RT_LO  = 10;

   // Decoded control bundle carried into the ID/EX register
   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       wai;
      logic       alusrc;
      logic [2:0] aluop;
      logic       is_jump;
      logic       is_brz;
      logic       is_brn;
   } ctrl_t;

endpackage

// File: rtl/stage2_regfile64.sv
// 64-entry register file with two combinational read ports, one write port,
// asynchronous clear, and write-through bypass so a same-cycle write is seen.
module regfile64
   import stage2_pkg::*;
#(
   parameter int DW  = DATA_W,
   parameter int RAW = REG_AW
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [RAW-1:0] rs,
   input  logic [RAW-1:0] rt,
   input  logic           we,
   input  logic [RAW-1:0] wa,
   input  logic [DW-1:0]  wd,
   output logic [DW-1:0]  rd1,
   output logic [DW-1:0]  rd2
);

   logic [DW-1:0] mem [(1<<RAW)];

   // Storage: cleared by reset, written on the rising edge when enabled
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < (1<<RAW); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wa] <= wd;
      end
   end

   // Read ports forward the incoming write data when addresses collide
   always_comb begin
      rd1 = mem[rs];
      rd2 = mem[rt];
      if (we && (wa == rs)) rd1 = wd;
      if (we && (wa == rt)) rd2 = wd;
   end

endmodule

// File: rtl/stage2.sv
// Decode / register-read stage: decodes the fetched instruction, reads the
// register file, sign-extends the immediate and registers it all into ID/EX.
module stage2
   import stage2_pkg::*;
#(
   parameter int DW   = DATA_W,
   parameter int RAW  = REG_AW,
   parameter int IMMW = IMM_W
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [DW-1:0]  instr,
   input  logic [DW-1:0]  in_PC,
   input  logic           stall,
   input  logic           flush,
   input  logic           wb_regWrite,
   input  logic [RAW-1:0] wb_rd,
   input  logic [DW-1:0]  wb_data,
   output logic           memWrite,
   output logic           memRead,
   output logic           ALUSRC,
   output logic [2:0]     ALUOP,
   output logic [DW-1:0]  rd1,
   output logic [DW-1:0]  rd2,
   output logic [DW-1:0]  imm,
   output logic           regWrite,
   output logic           WAI,
   output logic [DW-1:0]  PC,
   output logic [RAW-1:0] rd,
   output logic           isJump,
   output logic           isBrz,
   output logic           isBrn
);

   logic [3:0]     opcode;
   logic [RAW-1:0] rd_field;
   logic [RAW-1:0] rs_field;
   logic [RAW-1:0] rt_field;
   logic [DW-1:0]  imm_ext;
   logic [DW-1:0]  read_a;
   logic [DW-1:0]  read_b;
   ctrl_t          ctrl;

   assign opcode   = instr[OPC_HI:OPC_LO];
   assign rd_field = instr[RD_HI:RD_LO];
   assign rs_field = instr[RS_HI:RS_LO];
   assign rt_field = instr[RT_HI:RT_LO];
   assign imm_ext  = {{(DW-IMMW){instr[IMMW-1]}}, instr[IMMW-1:0]};

   regfile64 #(.DW(DW), .RAW(RAW)) u_regfile (
      .clock (clock),
      .reset (reset),
      .rs    (rs_field),
      .rt    (rt_field),
      .we    (wb_regWrite),
      .wa    (wb_rd),
      .wd    (wb_data),
      .rd1   (read_a),
      .rd2   (read_b)
   );

   // Control decode; anything not listed behaves as a NOP
   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_SVPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.wai       = 1'b1;
            ctrl.alusrc    = 1'b1;
            ctrl.aluop     = ALU_ADD;
         end
         OP_LD: begin
            ctrl.reg_write = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.aluop     = ALU_PASSA;
         end
         OP_ST: begin
            ctrl.mem_write = 1'b1;
            ctrl.aluop     = ALU_PASSA;
         end
         OP_ADD: begin
            ctrl.reg_write = 1'b1;
            ctrl.aluop     = ALU_ADD;
         end
         OP_INC: begin
            ctrl.reg_write = 1'b1;
            ctrl.alusrc    = 1'b1;
            ctrl.aluop     = ALU_ADD;
         end
         OP_NEG: begin
            ctrl.reg_write = 1'b1;
            ctrl.aluop     = ALU_NEG;
         end
         OP_SUB: begin
            ctrl.reg_write = 1'b1;
            ctrl.aluop     = ALU_SUB;
         end
         OP_J, OP_JM: begin
            ctrl.is_jump = 1'b1;
            ctrl.aluop   = ALU_PASSA;
         end
         OP_BRZ: begin
            ctrl.is_brz = 1'b1;
            ctrl.aluop  = ALU_PASSA;
         end
         OP_BRN: begin
            ctrl.is_brn = 1'b1;
            ctrl.aluop  = ALU_PASSA;
         end
         default: ctrl = '0;
      endcase
   end

   // ID/EX register: flush inserts a bubble and beats stall, stall holds
   always_ff @(posedge clock or posedge reset) begin
      if (reset || flush) begin
         regWrite <= 1'b0;
         memRead  <= 1'b0;
         memWrite <= 1'b0;
         WAI      <= 1'b0;
         ALUSRC   <= 1'b0;
         ALUOP    <= '0;
         isJump   <= 1'b0;
         isBrz    <= 1'b0;
         isBrn    <= 1'b0;
         rd1      <= '0;
         rd2      <= '0;
         imm      <= '0;
         PC       <= '0;
         rd       <= '0;
      end else if (!stall) begin
         regWrite <= ctrl.reg_write;
         memRead  <= ctrl.mem_read;
         memWrite <= ctrl.mem_write;
         WAI      <= ctrl.wai;
         ALUSRC   <= ctrl.alusrc;
         ALUOP    <= ctrl.aluop;
         isJump   <= ctrl.is_jump;
         isBrz    <= ctrl.is_brz;
         isBrn    <= ctrl.is_brn;
         rd1      <= read_a;
         rd2      <= read_b;
         imm      <= imm_ext;
         PC       <= in_PC;
         rd       <= rd_field;
      end
   end

endmodule
